// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU.
// Takes one operand bit per clock and writes lo/hi after WIDTH steps.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               is_div_q;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_d;
  logic [WIDTH-1:0]   hi_d;

  // Operand conditioning at issue: magnitudes and the sign fix-ups applied at the end.
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;

  always_comb begin
    a_neg_c = op[0] & srca[WIDTH-1];
    b_neg_c = op[0] & srcb[WIDTH-1];
    a_mag_c = a_neg_c ? (~srca + WIDTH'(1)) : srca;
    b_mag_c = b_neg_c ? (~srcb + WIDTH'(1)) : srcb;
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   mul_next;
  logic [ACC_W-1:0]   div_sh;
  logic [WIDTH:0]     trial;
  logic [ACC_W-1:0]   div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    mul_sum  = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[ACC_W-2:0], 1'b0};
    trial    = div_sh[ACC_W-1:WIDTH] - {1'b0, opnd_q};
    div_next = trial[WIDTH] ? div_sh : {trial, div_sh[WIDTH-1:1], 1'b1};
    acc_d    = is_div_q ? div_next : mul_next;

    prod = acc_d[2*WIDTH-1:0];
    quot = acc_d[WIDTH-1:0];
    rem  = acc_d[2*WIDTH-1:WIDTH];
    if (neg_quot_q) begin
      prod = ~prod + (2*WIDTH)'(1);
      quot = ~quot + WIDTH'(1);
    end
    if (neg_rem_q) begin
      rem = ~rem + WIDTH'(1);
    end

    lo_d = prod[WIDTH-1:0];
    hi_d = prod[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      lo_d = div_zero_q ? '1 : quot;
      hi_d = div_zero_q ? a_raw_q : rem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            is_div_q   <= op[1];
            neg_quot_q <= a_neg_c ^ b_neg_c;
            neg_rem_q  <= a_neg_c;
            div_zero_q <= op[1] & (srcb == '0);
            a_raw_q    <= srca;
            // Multiply adds the multiplicand while shifting the multiplier out;
            // divide shifts the dividend in and subtracts the divisor.
            opnd_q     <= op[1] ? b_mag_c : a_mag_c;
            acc_q      <= {(WIDTH + 1)'(0), op[1] ? a_mag_c : b_mag_c};
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative 32-bit multiply/divide unit that produces the lo/hi special-register values for MULT, MULTU, DIV and DIVU. It sits between the register-file read ports (srca/srcb) and the lo/hi special registers, replacing the single-cycle combinational multiplier. It takes one operand bit per clock and asserts busy so the datapath stalls the PC and blocks further mul/div issue until the result is written.

Parameters:
WIDTH, 32, operand width; lo and hi are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  issue request; sampled only in IDLE or DONE
op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (op[1]=divide, op[0]=signed)
srca  input  WIDTH  multiplicand / dividend
srcb  input  WIDTH  multiplier / divisor
busy  output  1  high while an operation is in progress (state RUN)
done  output  1  one-cycle pulse: lo/hi were updated on the preceding edge
lo  output  WIDTH  product[WIDTH-1:0] or quotient
hi  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder

Behaviour:
- Reset (synchronous, any state): state=IDLE, busy=0, done=0, lo=0, hi=0, iteration counter=0. Reset mid-operation aborts the operation; no partial result reaches lo/hi.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch op, srca, srcb; go to RUN with counter=0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; start is ignored. After the WIDTH-th step edge, write the final lo/hi and go to DONE.
  - DONE: done=1 for this single cycle. If start=1, accept a new operation exactly as from IDLE; otherwise go to IDLE.
- Timing: start sampled at edge E0. busy=1 from E0 until E32. At E32 (WIDTH=32), lo and hi are updated and done=1 for the cycle E32..E33. Fixed 32-cycle latency for every op, including divide-by-zero.
- Operand capture: operands are latched at E0. Changes on srca/srcb/op after E0 have no effect.
- Signed ops: iterate on magnitudes (|srca|, |srcb|) and apply the sign correction before the E32 write.
  - MULT: full 64-bit two's-complement product.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- Unsigned ops: MULTU gives the full 64-bit unsigned product. DIVU gives the unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): lo=all ones, hi=srca as latched. No exception is raised.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- lo/hi hold their value between operations. They change only at the final step edge or on reset, never during RUN.
- done and busy are never high together.

Test Plan:
1. MULTU srca=FFFFFFFF, srcb=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. done high exactly one cycle, 32 edges after the start edge. busy high for the 32 preceding cycles.
2. MULT srca=FFFFFFFD (-3), srcb=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB. Then MULT 80000000 * 80000000 -> hi=40000000, lo=00000000.
3. DIV srca=FFFFFFF9 (-7), srcb=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU srca=7, srcb=2 -> lo=3, hi=1. DIV srca=7, srcb=FFFFFFFE -> lo=FFFFFFFD, hi=1.
4. DIVU srca=5, srcb=0 -> lo=FFFFFFFF, hi=5 after 32 cycles. DIV srca=80000000, srcb=FFFFFFFF -> lo=80000000, hi=0.
5. Start with MULTU 3*4; pulse start with different operands in RUN cycle 10 -> ignored, result lo=0000000C, hi=0. Assert start with DIVU 9/4 in the DONE cycle -> accepted with no IDLE gap; 32 edges later lo=2, hi=1.
6. Start MULT 6*7; assert reset at RUN cycle 10 -> next cycle busy=0, done=0, lo=hi=0. A following MULTU 6*7 completes normally with lo=0000002A, hi=0.
